// File: rtl/syn_ampl_bank.sv
//============================================================================
// Module   : syn_ampl_bank
// Purpose  : Multi-channel synaptic-kernel amplitude store for the
//            time-multiplexed neuron pipeline.
//            - Holds KER_NO signed amplitudes per neuron.
//            - Returns the amplitudes one cycle after a read request.
//            - Writes back the updated amplitudes SP_LAT cycles after the
//              request. The update can load or saturating-accumulate the
//              kernel, clear on a postsynaptic spike, or apply shift leak.
//            - After reset, a clear sequence zeroes the RAM while busy_o is
//              high.
// Ports    : clk_i       system clock
//            reset_i     asynchronous active-high reset
//            rd_en_i     issue one neuron update this cycle
//            rd_addr_i   neuron index (sampled with rd_en_i)
//            sp_in_i     presynaptic spike (sampled with rd_en_i)
//            ker_in_i    packed signed kernels, channel 0 in the LSBs
//            sp_out_i    postsynaptic spike for the op in write-back
//            busy_o      clear sequence running, rd_en_i ignored
//            ampl_out_o  pre-update amplitudes of the issued op
//            out_valid_o ampl_out_o valid
//            out_addr_o  address belonging to ampl_out_o
//            hazard_o    sticky same-address reissue flag
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module syn_ampl_bank #(
  parameter int NEURON_NO = 256,
  parameter int KER_NO    = 2,
  parameter int AMPL_WID  = 20,
  parameter int SP_LAT    = 2,
  parameter int ACCUM     = 0,
  parameter int DECAY_SH  = 0,
  localparam int AW       = $clog2(NEURON_NO),
  localparam int DW       = KER_NO * AMPL_WID
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          sp_in_i,
  input  logic [DW-1:0] ker_in_i,
  input  logic          sp_out_i,
  output logic          busy_o,
  output logic [DW-1:0] ampl_out_o,
  output logic          out_valid_o,
  output logic [AW-1:0] out_addr_o,
  output logic          hazard_o
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW-1:0] clr_cnt_q;

  // Pipeline: stage s holds the op issued s+1 cycles ago; the last stage
  // is the write-back stage.
  logic [SP_LAT-1:0] pipe_vld_q;
  logic [SP_LAT-1:0] pipe_sp_q;
  logic [AW-1:0]     pipe_addr_q [SP_LAT];
  logic [DW-1:0]     pipe_ker_q  [SP_LAT];
  logic [DW-1:0]     pipe_ampl_q [SP_LAT];

  logic          accept;
  logic          addr_hit;
  logic          wb_en;
  logic          wb_sp;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] rd_ampl;

  assign accept  = rd_en_i && (state_q == S_RUN);
  assign wb_en   = pipe_vld_q[SP_LAT-1];
  assign wb_sp   = pipe_sp_q[SP_LAT-1];
  assign wb_addr = pipe_addr_q[SP_LAT-1];

  // Clear sequencer: one address per cycle, then hand over to normal ops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      busy_o    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(NEURON_NO - 1)) begin
            state_q <= S_RUN;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RUN;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // A hit against stages 0..SP_LAT-2 means the earlier op has not yet
  // written back, so this read sees a stale value.
  always_comb begin
    addr_hit = 1'b0;
    for (int s = 0; s < SP_LAT - 1; s++) begin
      if (pipe_vld_q[s] && (pipe_addr_q[s] == rd_addr_i)) begin
        addr_hit = 1'b1;
      end
    end
  end

  for (genvar c = 0; c < KER_NO; c++) begin : g_ch
    logic        [AMPL_WID-1:0] ram_q [NEURON_NO];
    logic signed [AMPL_WID-1:0] a_s;
    logic signed [AMPL_WID-1:0] k_s;
    logic signed [AMPL_WID-1:0] leak_s;
    logic signed [AMPL_WID-1:0] new_s;
    logic signed [AMPL_WID:0]   sum_s;

    assign a_s = pipe_ampl_q[SP_LAT-1][c*AMPL_WID +: AMPL_WID];
    assign k_s = pipe_ker_q[SP_LAT-1][c*AMPL_WID +: AMPL_WID];

    if (DECAY_SH > 0) begin : g_leak
      assign leak_s = a_s - (a_s >>> DECAY_SH);
    end else begin : g_noleak
      assign leak_s = a_s;
    end

    // One extra bit of headroom; overflow shows up as the top two bits
    // disagreeing.
    assign sum_s = {leak_s[AMPL_WID-1], leak_s} + {k_s[AMPL_WID-1], k_s};

    always_comb begin
      new_s = leak_s;
      if (wb_sp) begin
        if (ACCUM != 0) begin
          if (sum_s[AMPL_WID] != sum_s[AMPL_WID-1]) begin
            new_s = sum_s[AMPL_WID] ? {1'b1, {(AMPL_WID-1){1'b0}}}
                                    : {1'b0, {(AMPL_WID-1){1'b1}}};
          end else begin
            new_s = sum_s[AMPL_WID-1:0];
          end
        end else begin
          new_s = k_s;
        end
      end else if (sp_out_i) begin
        new_s = '0;
      end
    end

    // Storage carries no reset; the clear sequence initialises it.
    always_ff @(posedge clk_i) begin
      if (state_q == S_CLEAR) begin
        ram_q[clr_cnt_q] <= '0;
      end else if (wb_en) begin
        ram_q[wb_addr] <= new_s;
      end
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    assign rd_ampl[c*AMPL_WID +: AMPL_WID] =
      (wb_en && (wb_addr == rd_addr_i)) ? new_s : ram_q[rd_addr_i];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_vld_q  <= '0;
      pipe_sp_q   <= '0;
      for (int s = 0; s < SP_LAT; s++) begin
        pipe_addr_q[s] <= '0;
        pipe_ker_q[s]  <= '0;
        pipe_ampl_q[s] <= '0;
      end
      ampl_out_o  <= '0;
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
      hazard_o    <= 1'b0;
    end else begin
      pipe_vld_q[0]  <= accept;
      pipe_sp_q[0]   <= sp_in_i;
      pipe_addr_q[0] <= rd_addr_i;
      pipe_ker_q[0]  <= ker_in_i;
      pipe_ampl_q[0] <= rd_ampl;
      for (int s = 1; s < SP_LAT; s++) begin
        pipe_vld_q[s]  <= pipe_vld_q[s-1];
        pipe_sp_q[s]   <= pipe_sp_q[s-1];
        pipe_addr_q[s] <= pipe_addr_q[s-1];
        pipe_ker_q[s]  <= pipe_ker_q[s-1];
        pipe_ampl_q[s] <= pipe_ampl_q[s-1];
      end
      out_valid_o <= accept;
      ampl_out_o  <= accept ? rd_ampl : '0;
      out_addr_o  <= accept ? rd_addr_i : '0;
      hazard_o    <= hazard_o | (accept & addr_hit);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_syn_ampl_bank.sv
//============================================================================
// Module   : tb_syn_ampl_bank
// Purpose  : Self-checking bench for syn_ampl_bank. Three instances share
//            one stimulus stream: load/no-leak, accumulate/no-leak and
//            load/leak(2). A reference model predicts each read and queues
//            the predictions, and a monitor pops and compares them.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_syn_ampl_bank;

  localparam int NN   = 256;
  localparam int W    = 20;
  localparam int LAT  = 2;
  localparam int AW   = 8;
  localparam int DW   = 2 * W;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          sp_in;
  logic [DW-1:0] ker;
  logic          sp_out;
  logic [2:0]    busy, ov, hz;
  logic [DW-1:0] ao [3];
  logic [AW-1:0] oa [3];

  syn_ampl_bank #(.NEURON_NO(NN), .KER_NO(2), .AMPL_WID(W), .SP_LAT(LAT),
                  .ACCUM(0), .DECAY_SH(0)) u_load (
    .clk_i(clk), .reset_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .sp_in_i(sp_in), .ker_in_i(ker), .sp_out_i(sp_out), .busy_o(busy[0]),
    .ampl_out_o(ao[0]), .out_valid_o(ov[0]), .out_addr_o(oa[0]),
    .hazard_o(hz[0]));

  syn_ampl_bank #(.NEURON_NO(NN), .KER_NO(2), .AMPL_WID(W), .SP_LAT(LAT),
                  .ACCUM(1), .DECAY_SH(0)) u_acc (
    .clk_i(clk), .reset_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .sp_in_i(sp_in), .ker_in_i(ker), .sp_out_i(sp_out), .busy_o(busy[1]),
    .ampl_out_o(ao[1]), .out_valid_o(ov[1]), .out_addr_o(oa[1]),
    .hazard_o(hz[1]));

  syn_ampl_bank #(.NEURON_NO(NN), .KER_NO(2), .AMPL_WID(W), .SP_LAT(LAT),
                  .ACCUM(0), .DECAY_SH(2)) u_leak (
    .clk_i(clk), .reset_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .sp_in_i(sp_in), .ker_in_i(ker), .sp_out_i(sp_out), .busy_o(busy[2]),
    .ampl_out_o(ao[2]), .out_valid_o(ov[2]), .out_addr_o(oa[2]),
    .hazard_o(hz[2]));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } sb_t;

  sb_t   sbq [$];
  string tq  [$];
  int    mdl [3][NN][2];
  int    acc_t [3] = '{0, 1, 0};
  int    ds_t  [3] = '{0, 0, 2};
  logic [7:0] pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int c0, input int c1);
    logic [DW-1:0] p;
    p[W-1:0]  = c0[W-1:0];
    p[DW-1:W] = c1[W-1:0];
    return p;
  endfunction

  function automatic int nxt(input int a, input int k, input bit sp, input bit spo,
                             input int acc, input int ds);
    int d;
    int s;
    d = (ds > 0) ? a - (a >>> ds) : a;
    if (sp) begin
      if (acc == 0) return k;
      s = d + k;
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      return s;
    end
    if (spo) return 0;
    return d;
  endfunction

  // One clock cycle of stimulus; sp_out for an op is delivered LAT cycles
  // after it is issued.
  task automatic cyc(input bit r, input int a, input bit sp, input logic [DW-1:0] k,
                     input bit spo);
    rd_en   = r;
    rd_addr = AW'(a);
    sp_in   = sp;
    ker     = k;
    sp_out  = pend[0];
    if (r) pend[LAT] = spo;
    @(posedge clk);
    #1;
    pend = pend >> 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic issue(input string tag, input int a, input bit sp, input int k0,
                       input int k1, input bit spo);
    sb_t e;
    e.a  = AW'(a);
    e.e0 = pk(mdl[0][a][0], mdl[0][a][1]);
    e.e1 = pk(mdl[1][a][0], mdl[1][a][1]);
    e.e2 = pk(mdl[2][a][0], mdl[2][a][1]);
    sbq.push_back(e);
    tq.push_back(tag);
    for (int d = 0; d < 3; d++) begin
      mdl[d][a][0] = nxt(mdl[d][a][0], k0, sp, spo, acc_t[d], ds_t[d]);
      mdl[d][a][1] = nxt(mdl[d][a][1], k1, sp, spo, acc_t[d], ds_t[d]);
    end
    cyc(1'b1, a, sp, pk(k0, k1), spo);
  endtask

  // Issue, then leave the slot free until its write-back cycle.
  task automatic op(input string tag, input int a, input bit sp, input int k0,
                    input int k1, input bit spo);
    issue(tag, a, sp, k0, k1, spo);
    idle(LAT - 1);
  endtask

  always @(negedge clk) begin : m_mon
    sb_t   e;
    string t;
    if (ov != 3'b000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 64'(ov), 64'd0);
      end else begin
        e = sbq.pop_front();
        t = tq.pop_front();
        chk({t, "_valid"}, 64'(ov), 64'h7);
        chk({t, "_load"},  64'({oa[0], ao[0]}), 64'({e.a, e.e0}));
        chk({t, "_acc"},   64'({oa[1], ao[1]}), 64'({e.a, e.e1}));
        chk({t, "_leak"},  64'({oa[2], ao[2]}), 64'({e.a, e.e2}));
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    sp_in   = 1'b0;
    ker     = '0;
    sp_out  = 1'b0;
    pend    = '0;
    foreach (mdl[d, a, c]) mdl[d][a][c] = 0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(busy), 64'h7);
    chk("rst_ampl",  64'(ao[0] | ao[1] | ao[2]), 64'd0);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_addr",  64'(oa[0] | oa[1] | oa[2]), 64'd0);
    chk("rst_hazard", 64'(hz), 64'd0);
    rst = 1'b0;

    // Clear sequence: a request in the first busy cycle must be dropped.
    n = 0;
    while (busy[0] && n < 400) begin
      cyc(n == 0, 5, 1'b1, pk(7, 7), 1'b0);
      n++;
      if (n == 1) chk("busy_drop", 64'(ov), 64'd0);
    end
    chk("busy_cycles", 64'(n), 64'(NN));
    chk("busy_all_low", 64'(busy), 64'd0);

    op("rd5_cleared", 5, 1'b0, 0, 0, 1'b0);

    // Load then reissue exactly at the write-back cycle (bypass).
    issue("ld3", 3, 1'b1, -7, 100, 1'b0);
    idle(LAT - 1);
    op("byp3", 3, 1'b0, 0, 0, 1'b0);

    // Postsynaptic reset and sp_in priority.
    op("ld3b", 3, 1'b1, 100, 100, 1'b0);
    op("spo_clr", 3, 1'b0, 0, 0, 1'b1);
    op("spo_prio", 3, 1'b1, 50, 50, 1'b1);
    op("rd50", 3, 1'b0, 0, 0, 1'b0);

    // Saturation at both rails.
    op("acc_a", 20, 1'b1, MAXV - 9, MINV, 1'b0);
    op("acc_b", 20, 1'b1, 20, -1, 1'b0);
    op("acc_rd", 20, 1'b0, 0, 0, 1'b0);

    // Leak chain.
    op("lk_ld", 30, 1'b1, 64, -100, 1'b0);
    for (int i = 0; i < 4; i++) op("lk_idle", 30, 1'b0, 0, 0, 1'b0);

    // Distinct back-to-back addresses, then a same-address reissue.
    for (int i = 0; i < 4; i++) issue("b2b", 40 + i, 1'b0, 0, 0, 1'b0);
    idle(LAT + 1);
    chk("haz_distinct", 64'(hz), 64'd0);
    issue("hz9a", 9, 1'b0, 0, 0, 1'b0);
    issue("hz9b", 9, 1'b0, 0, 0, 1'b0);
    idle(2);
    chk("haz_set", 64'(hz), 64'h7);
    idle(5);
    chk("haz_sticky", 64'(hz), 64'h7);

    // Reset mid-operation: the in-flight write must be discarded.
    issue("pre_rst", 50, 1'b1, 123, -5, 1'b0);
    @(negedge clk);
    #1;
    rst  = 1'b1;
    pend = '0;
    foreach (mdl[d, a, c]) mdl[d][a][c] = 0;
    chk("q_empty_at_rst", 64'(sbq.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_hazard", 64'(hz), 64'd0);
    chk("rst2_busy", 64'(busy), 64'h7);
    rst = 1'b0;
    n = 0;
    while (busy[0] && n < 400) begin
      idle(1);
      n++;
    end
    chk("busy_cycles2", 64'(n), 64'(NN));
    op("post_rst50", 50, 1'b0, 0, 0, 1'b0);
    op("post_rst3", 3, 1'b0, 0, 0, 1'b0);
    idle(3);
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/syn_ampl_bank.md
# syn_ampl_bank

Multi-channel synaptic-kernel amplitude store for the time-multiplexed neuron pipeline. It holds KER_NO signed amplitudes per neuron. It returns them one cycle after a read request and writes back an updated value SP_LAT cycles later. The update can load or saturating-accumulate the incoming kernel, reset on a postsynaptic spike, and apply shift-based leak. It replaces the fixed two-channel, load-only amplitude RAM and adds a post-reset RAM clear sequence and hazard detection.

## Interface
- NEURON_NO, 256: neurons served; address width AW = $clog2(NEURON_NO)
- KER_NO, 2: kernel channels per neuron
- AMPL_WID, 20: signed amplitude width per channel
- SP_LAT, 2: cycles from rd_en to sp_out/write-back, legal range 1..4
- ACCUM, 0: 0 = sp_in loads ker_in; 1 = sp_in adds ker_in with saturation
- DECAY_SH, 0: leak shift; 0 = no leak
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_en  in  1  issue one neuron update this cycle
- rd_addr  in  AW  neuron index, sampled with rd_en
- sp_in  in  1  presynaptic spike for this op, sampled with rd_en
- ker_in  in  KER_NO*AMPL_WID  packed signed kernel amplitudes, channel 0 in the LSBs, sampled with rd_en
- sp_out  in  1  postsynaptic spike for the op issued SP_LAT cycles earlier
- busy  out  1  clear sequence running; rd_en ignored
- ampl_out  out  KER_NO*AMPL_WID  pre-update amplitudes of the issued op
- out_valid  out  1  ampl_out valid
- out_addr  out  AW  address belonging to ampl_out
- hazard  out  1  sticky: same address reissued fewer than SP_LAT cycles after an earlier op

## Operation
- Storage is KER_NO distributed arrays of NEURON_NO x AMPL_WID. The array is not reset asynchronously.
- Clear FSM has states CLEAR and RUN.
  - reset forces CLEAR with clr_cnt = 0 and busy = 1.
  - CLEAR writes 0 to address clr_cnt in all channels each cycle.
  - After clr_cnt = NEURON_NO-1 is written, the FSM goes to RUN and busy falls the next cycle.
  - Total clear time is NEURON_NO cycles after reset deasserts.
- rd_en while busy is dropped: no output and no pipeline entry.
- Each accepted op is carried through a SP_LAT-deep pipeline with its addr, sp_in, ker_in and the read amplitudes.
- Write-back happens at the cycle of sp_out for that op. Per channel, with a = read amplitude and k = kernel:
  - leak: d = a - (a >>> DECAY_SH) if DECAY_SH > 0, else d = a
  - sp_in = 1: new = k if ACCUM = 0; new = sat(d + k) if ACCUM = 1
  - sp_in = 0 and sp_out = 1: new = 0
  - sp_in = 0 and sp_out = 0: new = d
  - sp_in takes priority over sp_out.
- sat clamps to [-2^(AMPL_WID-1), 2^(AMPL_WID-1)-1]. The add is computed at AMPL_WID+1 bits.
- Write-first bypass: if an op reads an address in the same cycle that an older op writes it, ampl_out returns the newly written value.
- Hazard: if an address is issued again within 1..SP_LAT-1 cycles of an earlier op to the same address, hazard is set (sticky until reset). Both write-backs still occur in order; the last writer wins.

## Timing
- Reset values: busy = 1, ampl_out = 0, out_valid = 0, out_addr = 0, hazard = 0. All pipeline valids are 0.
- Accepted rd_en at cycle t gives out_valid = 1 and ampl_out/out_addr at t+1, registered.
- sp_out is sampled at t+SP_LAT. The RAM is written at the clock edge ending t+SP_LAT.
- Throughput is one op per cycle. There is no back-pressure; the pipeline never stalls.
- When the op is idle, ampl_out returns to 0 and out_valid is 0.
- Reset asserted mid-operation discards in-flight ops; no write-back occurs. The clear sequence restarts from address 0.
- sp_out is ignored in cycles where no op is in the write-back stage.

## Test plan
- Reset, then release: busy stays high for exactly NEURON_NO cycles. A read of addr 5 then returns 0 on all channels, and a rd_en issued while busy produces no out_valid.
- ACCUM = 0, DECAY_SH = 0:
  - Op on addr 3 with sp_in = 1 and ker = {100, -7}.
  - Reissue addr 3 SP_LAT cycles later: ampl_out = {100, -7} at the following cycle (bypass path).
- Same configuration, load 100 into addr 3, then an op with sp_out = 1 and sp_in = 0: the next read returns 0. An op with both sp_in = 1 (ker 50) and sp_out = 1 stores 50.
- ACCUM = 1, AMPL_WID = 20:
  - Accumulating 2^19-10 with +20 saturates to 524287.
  - Accumulating -2^19 with -1 saturates to -524288.
- DECAY_SH = 2: stored 64 reads back 48, then 36, then 27 on successive idle ops (sp_in = sp_out = 0).
- Issue addr 9 at t and again at t+1 with SP_LAT = 2: hazard rises and stays high; ops to distinct addresses back-to-back never raise it.
